multicycle_mem_responder: RTL and testbench

//  Memory responder for the multi-cycle MIPS datapath. It services the MemRead/MemWrite strobes

---
 rtl/multicycle_mem_responder.sv | 143 ++++++++++++++
 tb/tb_multicycle_mem_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle MIPS datapath.
// Latency: request captured at edge t0, mem_ready high during the WAIT_CYCLES+1'th cycle after t0.
// Backpressure: none; strobes/addr are ignored while busy, requester drops its strobe on mem_ready.
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag addr[1:0]!=0 with mem_err instead of committing.
module multicycle_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    mis_d;
    logic                    commit;
    logic                    do_wr;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    logic addr_unused;
    assign addr_unused = ^addr[ADDR_W-1:DEPTH_LOG2+2];
`else
    // Byte offset and aliasing upper bits carry no meaning for word accesses.
    logic addr_unused;
    assign addr_unused = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};
`endif

    // Next-state, capture and commit decode; _d values are the live request in IDLE,
    // the captured request otherwise, so commit logic works for WAIT_CYCLES==0 too.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`else
        mis_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    we_d    = mem_write;
                    idx_d   = addr[DEPTH_LOG2+1:2];
                    wdata_d = wdata;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_d   = (addr[1:0] != 2'b00);
`endif
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        commit  = (state_d == S_RESP) && (state_q != S_RESP) && !rst;
        do_wr   = commit && we_d && !mis_d;
        rdata_d = (commit && !we_d && !mis_d) ? mem[idx_d] : rdata_q;
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        err_d   = (state_d == S_RESP) && mis_d;
    end

    // Control and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Array write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[idx_d] <= wdata_d;
    end

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: WAIT_CYCLES=2 instance (table driven) and WAIT_CYCLES=0 instance.
// Latency: checked per access against the expected WAIT_CYCLES+1 cycles.
// Backpressure: n/a; strobes dropped right after capture with address/data scrambled.
module tb_multicycle_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mr = '0;
    logic [1:0]  mw = '0;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic [1:0]  rdy;
    logic [1:0]  bsy;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .mem_read(mr[0]), .mem_write(mw[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]),
        .mem_ready(rdy[0]), .mem_busy(bsy[0]), .mem_err(err[0])
    );

    multicycle_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .mem_read(mr[1]), .mem_write(mw[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]),
        .mem_ready(rdy[1]), .mem_busy(bsy[1]), .mem_err(err[1])
    );

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One complete access on instance sel; checks latency, held outputs and return to idle.
    task automatic access(input int sel, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e,
                          input string nm);
        int k;
        int lat;
        lat = (sel == 1) ? 1 : 3;
        @(negedge clk);
        mr[sel] = r; mw[sel] = w; ad[sel] = a; wd[sel] = d;
        @(posedge clk);
        #1;
        mr[sel] = 1'b0; mw[sel] = 1'b0; ad[sel] = 32'hFFFF_FFF0; wd[sel] = 32'h0BAD_0BAD;
        k = 1;
        while (!rdy[sel] && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " busy@ready"}, 32'(bsy[sel]), 32'd1);
        chk({nm, " err"}, 32'(err[sel]), 32'(exp_e));
        chk({nm, " rdata"}, rd[sel], exp_rd);
        @(posedge clk);
        #1;
        chk({nm, " ready pulse end"}, 32'(rdy[sel]), 32'd0);
        chk({nm, " busy end"}, 32'(bsy[sel]), 32'd0);
        chk({nm, " err end"}, 32'(err[sel]), 32'd0);
    endtask

    initial begin
        logic trap;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        //          rd    wr    addr          wdata          exp_rdata                     err
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "wr 0x10"};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd 0x10"};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, "wr 0x1004"};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_1234, 1'b0, "rd 0x4 wrap"};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'h0000_1234, 1'b0, "both 0x20"};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0055, 1'b0, "rd 0x20"};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0000_0099, 32'h0000_0055, trap, "wr 0x22"};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,
                    trap ? 32'h0000_0055 : 32'h0000_0099, 1'b0, "rd mem8"};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFF_C010, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd 0x10 alias"};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, "wr 0x40"};

        ad[0] = '0; wd[0] = '0; ad[1] = '0; wd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rdata", rd[0], 32'h0);
        chk("reset ready", 32'(rdy[0]), 32'd0);
        chk("reset busy", 32'(bsy[0]), 32'd0);
        chk("reset err", 32'(err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            access(0, vecs[i].rd_en, vecs[i].wr_en, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);

        // Reset mid-WAIT of a write to 0x40: access aborted, write not committed.
        @(negedge clk);
        mw[0] = 1'b1; ad[0] = 32'h40; wd[0] = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        mw[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-wait busy", 32'(bsy[0]), 32'd1);
        chk("mid-wait ready", 32'(rdy[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort rdata", rd[0], 32'h0);
        chk("abort ready", 32'(rdy[0]), 32'd0);
        chk("abort busy", 32'(bsy[0]), 32'd0);
        chk("abort err", 32'(err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b0, "rd 0x40 after abort");

        // Zero wait-state instance: response in the first cycle after capture, busy one cycle.
        access(1, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0, "w0 wr 0x0");
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "w0 rd 0x0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
